// File: rtl/ysyx_23060332_wbu_if.sv
// EXU-to-WBU instruction handshake, data-memory read channel and register-file write port.
// The master modport is the environment (EXU, memory, regfile); the slave modport is the WBU.
interface ysyx_23060332_wbu_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        reg_wen;
    logic        wb_done;
    logic        err;

    modport master (
        output in_valid, in_rd, in_result, in_is_load, in_funct3,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  in_ready, mem_req_valid, mem_addr,
        input  waddr, wdata, reg_wen, wb_done, err
    );

    modport slave (
        input  in_valid, in_rd, in_result, in_is_load, in_funct3,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output in_ready, mem_req_valid, mem_addr,
        output waddr, wdata, reg_wen, wb_done, err
    );
endinterface

// File: rtl/ysyx_23060332_wbu.sv
// Write-back unit: retires ALU results directly and performs aligned loads with sign/zero extraction.
// Optional load timeout with sticky err is enabled by defining YSYX_23060332_WBU_TIMEOUT_EN.
module ysyx_23060332_wbu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    ysyx_23060332_wbu_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    state_t      state_q, state_d;
    logic [4:0]  rd_q;
    logic [31:0] res_q;
    logic [2:0]  f3_q;
    logic        ld_q;
    logic [31:0] ext_q;

    function automatic logic [31:0] load_ext(input logic [31:0] d,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] sh;
        sh = d >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'h0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'h0, h};
            default: load_ext = d;
        endcase
    endfunction

`ifdef YSYX_23060332_WBU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             timeout_hit;

    // A response on the final counted cycle still wins over the timeout.
    assign timeout_hit = (state_q == WAIT) && !bus.mem_resp_valid &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q != WAIT)
                cnt_q <= '0;
            else if (!bus.mem_resp_valid)
                cnt_q <= cnt_q + 1'b1;
            err_q <= err_q | timeout_hit;
        end
    end

    assign bus.err = err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid) state_d = bus.in_is_load ? REQ : WB;
            REQ:  if (bus.mem_req_ready) state_d = WAIT;
            WAIT: begin
                if (bus.mem_resp_valid)
                    state_d = WB;
`ifdef YSYX_23060332_WBU_TIMEOUT_EN
                else if (timeout_hit)
                    state_d = IDLE;
`endif
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= 5'd0;
            res_q <= 32'd0;
            f3_q  <= 3'd0;
            ld_q  <= 1'b0;
            ext_q <= 32'd0;
        end else begin
            if (state_q == IDLE && bus.in_valid) begin
                rd_q  <= bus.in_rd;
                res_q <= bus.in_result;
                f3_q  <= bus.in_funct3;
                ld_q  <= bus.in_is_load;
            end
            if (state_q == WAIT && bus.mem_resp_valid)
                ext_q <= load_ext(bus.mem_rdata, res_q[1:0], f3_q);
        end
    end

    // Every output below is a decode of state or latched registers only.
    assign bus.in_ready      = (state_q == IDLE);
    assign bus.mem_req_valid = (state_q == REQ);
    assign bus.mem_addr      = {res_q[31:2], 2'b00};
    assign bus.waddr         = rd_q;
    assign bus.wdata         = ld_q ? ext_q : res_q;
    assign bus.wb_done       = (state_q == WB);
    assign bus.reg_wen       = (state_q == WB) && (rd_q != 5'd0);

endmodule

// File: tb/tb_ysyx_23060332_wbu.sv
// Directed bench for the write-back unit: vector table of single instructions plus hand sequences
// for memory backpressure, stray responses, reset during WAIT and load timeout.
module tb_ysyx_23060332_wbu;

`ifdef YSYX_23060332_WBU_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    ysyx_23060332_wbu_if bus ();

    ysyx_23060332_wbu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_wen;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input logic ld, input logic [4:0] rd,
                               input logic [31:0] res, input logic [2:0] f3);
        bus.in_valid   = 1'b1;
        bus.in_is_load = ld;
        bus.in_rd      = rd;
        bus.in_result  = res;
        bus.in_funct3  = f3;
        tick();
        bus.in_valid   = 1'b0;
        bus.in_is_load = 1'b0;
        bus.in_rd      = 5'd0;
        bus.in_result  = 32'd0;
        bus.in_funct3  = 3'd0;
    endtask

    // Accepts a load and gets the request taken at once; returns in the first WAIT cycle.
    task automatic start_load(input logic [4:0] rd, input logic [31:0] res, input logic [2:0] f3);
        drive_instr(1'b1, rd, res, f3);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        chk({p, "_idle_rdy"}, 32'(bus.in_ready), 32'd1);
        drive_instr(v.ld, v.rd, v.res, v.f3);
        if (v.ld) begin
            chk({p, "_req_vld"}, 32'(bus.mem_req_valid), 32'd1);
            chk({p, "_addr"}, bus.mem_addr, v.exp_addr);
            bus.mem_req_ready = 1'b1;
            tick();
            bus.mem_req_ready = 1'b0;
            chk({p, "_wait_rdy"}, 32'(bus.in_ready), 32'd0);
            chk({p, "_wait_done"}, 32'(bus.wb_done), 32'd0);
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = v.rdata;
            tick();
            bus.mem_resp_valid = 1'b0;
            bus.mem_rdata      = 32'hA5A5_A5A5;
        end
        chk({p, "_done"}, 32'(bus.wb_done), 32'd1);
        chk({p, "_wen"}, 32'(bus.reg_wen), 32'(v.exp_wen));
        chk({p, "_waddr"}, 32'(bus.waddr), 32'(v.rd));
        chk({p, "_wdata"}, bus.wdata, v.exp_wdata);
        chk({p, "_wb_rdy"}, 32'(bus.in_ready), 32'd0);
        tick();
        chk({p, "_post_wen"}, 32'(bus.reg_wen), 32'd0);
        chk({p, "_post_done"}, 32'(bus.wb_done), 32'd0);
    endtask

    task automatic chk_reset_state(input string p);
        chk({p, "_rdy"}, 32'(bus.in_ready), 32'd1);
        chk({p, "_req"}, 32'(bus.mem_req_valid), 32'd0);
        chk({p, "_wen"}, 32'(bus.reg_wen), 32'd0);
        chk({p, "_done"}, 32'(bus.wb_done), 32'd0);
        chk({p, "_err"}, 32'(bus.err), 32'd0);
        chk({p, "_waddr"}, 32'(bus.waddr), 32'd0);
        chk({p, "_wdata"}, bus.wdata, 32'd0);
        chk({p, "_addr"}, bus.mem_addr, 32'd0);
    endtask

    initial begin
        logic [31:0] addr0;

        //         ld    rd     result         f3    rdata          addr           wdata          wen
        vt[0]  = '{1'b0, 5'd5,  32'h1234_5678, 3'd0, 32'h0,         32'h1234_5678, 32'h1234_5678, 1'b1};
        vt[1]  = '{1'b1, 5'd7,  32'h8000_0003, 3'd0, 32'h80FF_0000, 32'h8000_0000, 32'hFFFF_FF80, 1'b1};
        vt[2]  = '{1'b1, 5'd7,  32'h8000_0003, 3'd4, 32'h80FF_0000, 32'h8000_0000, 32'h0000_0080, 1'b1};
        vt[3]  = '{1'b1, 5'd9,  32'h8000_0002, 3'd1, 32'h8001_7FFF, 32'h8000_0000, 32'hFFFF_8001, 1'b1};
        vt[4]  = '{1'b1, 5'd9,  32'h8000_0002, 3'd5, 32'h8001_7FFF, 32'h8000_0000, 32'h0000_8001, 1'b1};
        vt[5]  = '{1'b1, 5'd0,  32'h8000_0002, 3'd1, 32'h8001_7FFF, 32'h8000_0000, 32'hFFFF_8001, 1'b0};
        vt[6]  = '{1'b1, 5'd31, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1};
        vt[7]  = '{1'b1, 5'd3,  32'h8000_0003, 3'd1, 32'h8001_7FFF, 32'h8000_0000, 32'hFFFF_8001, 1'b1};
        vt[8]  = '{1'b1, 5'd4,  32'h0000_1001, 3'd0, 32'h0000_7F00, 32'h0000_1000, 32'h0000_007F, 1'b1};
        vt[9]  = '{1'b1, 5'd6,  32'h0000_2002, 3'd3, 32'hCAFE_F00D, 32'h0000_2000, 32'hCAFE_F00D, 1'b1};
        vt[10] = '{1'b0, 5'd0,  32'hFFFF_FFFF, 3'd0, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0};
        vt[11] = '{1'b1, 5'd12, 32'h0000_3000, 3'd5, 32'h1234_F00D, 32'h0000_3000, 32'h0000_F00D, 1'b1};

        bus.in_valid       = 1'b0;
        bus.in_rd          = 5'd0;
        bus.in_result      = 32'd0;
        bus.in_is_load     = 1'b0;
        bus.in_funct3      = 3'd0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'd0;

        tick();
        tick();
        rst = 1'b0;
        chk_reset_state("rst");

        for (int i = 0; i < 12; i++)
            run_vec(i, vt[i]);

        // Request backpressure: valid and address must hold until accepted.
        drive_instr(1'b1, 5'd8, 32'h4000_0006, 3'd5);
        addr0 = 32'h4000_0004;
        for (int i = 0; i < 3; i++) begin
            chk("bp_req_vld", 32'(bus.mem_req_valid), 32'd1);
            chk("bp_addr", bus.mem_addr, addr0);
            tick();
        end
        chk("bp_req_vld_last", 32'(bus.mem_req_valid), 32'd1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        chk("bp_req_drop", 32'(bus.mem_req_valid), 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hBEEF_1234;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("bp_wdata", bus.wdata, 32'h0000_BEEF);
        chk("bp_wen", 32'(bus.reg_wen), 32'd1);
        tick();

        // Stray responses while idle are ignored.
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h1111_2222;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stray_wen", 32'(bus.reg_wen), 32'd0);
            chk("stray_done", 32'(bus.wb_done), 32'd0);
            chk("stray_rdy", 32'(bus.in_ready), 32'd1);
        end
        bus.mem_resp_valid = 1'b0;

        // Reset while waiting abandons the load; a late response must not write.
        start_load(5'd10, 32'h5000_0000, 3'd2);
        chk("rw_in_wait", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state("rw");
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h7777_7777;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rw_late_wen", 32'(bus.reg_wen), 32'd0);
            chk("rw_late_done", 32'(bus.wb_done), 32'd0);
        end
        bus.mem_resp_valid = 1'b0;

`ifdef YSYX_23060332_WBU_TIMEOUT_EN
        // Response on the last counted WAIT cycle beats the timeout.
        start_load(5'd11, 32'h6000_0000, 3'd2);
        tick();
        tick();
        tick();
        chk("race_wait", 32'(bus.in_ready), 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0BAD_CAFE;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("race_done", 32'(bus.wb_done), 32'd1);
        chk("race_wdata", bus.wdata, 32'h0BAD_CAFE);
        chk("race_err", 32'(bus.err), 32'd0);
        tick();

        // Four silent WAIT cycles abandon the load and set the sticky flag.
        start_load(5'd11, 32'h6000_0000, 3'd2);
        tick();
        tick();
        tick();
        chk("to_wait4_rdy", 32'(bus.in_ready), 32'd0);
        chk("to_wait4_err", 32'(bus.err), 32'd0);
        tick();
        chk("to_err", 32'(bus.err), 32'd1);
        chk("to_rdy", 32'(bus.in_ready), 32'd1);
        chk("to_wen", 32'(bus.reg_wen), 32'd0);
        chk("to_done", 32'(bus.wb_done), 32'd0);
        run_vec(100, vt[0]);
        chk("to_sticky", 32'(bus.err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("to_rst_err", 32'(bus.err), 32'd0);
`else
        // Without the timeout, WAIT holds indefinitely and err stays low.
        start_load(5'd11, 32'h6000_0001, 3'd4);
        for (int i = 0; i < 10; i++)
            tick();
        chk("nto_rdy", 32'(bus.in_ready), 32'd0);
        chk("nto_err", 32'(bus.err), 32'd0);
        chk("nto_done", 32'(bus.wb_done), 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0000_9A00;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("nto_wdata", bus.wdata, 32'h0000_009A);
        chk("nto_wen", 32'(bus.reg_wen), 32'd1);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060332_wbu.md
YSYX_23060332_WBU -- requirements
Module: ysyx_23060332_wbu

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, number of WAIT cycles before a load is abandoned (used only with the macro in REQ-024).
REQ-002 clk  in  1  clock; all state updates on posedge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  EXU presents a completed instruction.
REQ-005 in_ready  out  1  WBU can accept an instruction this cycle.
REQ-006 in_rd  in  5  destination register index.
REQ-007 in_result  in  32  ALU result, or effective address for loads.
REQ-008 in_is_load  in  1  instruction is a load.
REQ-009 in_funct3  in  3  load width/sign code.
REQ-010 mem_req_valid / mem_req_ready / mem_addr  out / in / out  1 / 1 / 32  data-memory read request.
REQ-011 mem_resp_valid / mem_rdata  in / in  1 / 32  read response.
REQ-012 waddr / wdata / reg_wen  out / out / out  5 / 32 / 1  register-file write port.
REQ-013 wb_done  out  1  one-cycle retire pulse.
REQ-014 err  out  1  sticky load-timeout flag.

Function
REQ-015 The FSM SHALL have four states: IDLE, REQ, WAIT and WB; in_ready SHALL be 1 only in IDLE and SHALL depend on the state alone.
REQ-016 In IDLE with in_valid=1, the block SHALL latch rd, result, funct3 and is_load, then go to REQ if is_load=1, else to WB.
REQ-017 In REQ:
- mem_req_valid SHALL be 1.
- mem_addr SHALL be {result[31:2],2'b00}.
- The FSM SHALL move to WAIT on the cycle mem_req_ready=1, else hold; mem_req_valid SHALL stay high until accepted.
REQ-018 In WAIT, on mem_resp_valid=1 the block SHALL latch the extracted value and go to WB; mem_resp_valid in any other state SHALL be ignored.
REQ-019 Load extraction uses off = result[1:0]:
- funct3 000 (LB): byte at off, sign-extended.
- 100 (LBU): byte at off, zero-extended.
- 001 (LH): half at off[1], sign-extended.
- 101 (LHU): half at off[1], zero-extended.
- 010 (LW) and any other code: full word.
- off[0] SHALL be ignored for halfword loads.
REQ-020 In WB:
- wb_done SHALL be 1.
- waddr SHALL be the latched rd.
- wdata SHALL be the latched result (non-load) or the extracted value (load).
- reg_wen SHALL be 1 only if rd != 0.
- The next state SHALL be IDLE.
REQ-021 Latency:
- Non-load accepted in cycle N: reg_wen in cycle N+1.
- Load with mem_req_ready=1 and a response in the first WAIT cycle: accept N, request N+1, response N+2, reg_wen N+3.
REQ-022 Outputs other than in_ready SHALL come from state and latched registers only, with no combinational path from input ports.

Reset
REQ-023 With rst=1 at a posedge, from any state:
- The state SHALL become IDLE and an outstanding request SHALL be abandoned without a write.
- The next cycle SHALL have in_ready=1 and mem_req_valid=0, reg_wen=0, wb_done=0, err=0.
- waddr=0, wdata=0 and mem_addr=0.

Configuration
REQ-024 With YSYX_23060332_WBU_TIMEOUT_EN defined:
- A counter SHALL clear on entering WAIT and increment each WAIT cycle without a response.
- When it reaches TIMEOUT_CYCLES, err SHALL be set (sticky until rst) and the FSM SHALL return to IDLE with no reg_wen and no wb_done.
- A response arriving in the same cycle as the timeout SHALL win (normal WB, err unchanged).
REQ-025 Without the macro, no counter SHALL exist, err SHALL be constant 0, and WAIT SHALL wait indefinitely.

Verification
REQ-026 Non-load rd=5, result=0x1234_5678 accepted at cycle N -> cycle N+1: reg_wen=1, waddr=5, wdata=0x1234_5678, wb_done=1; in_ready=0 at N+1.
REQ-027 LB with addr 0x8000_0003 and mem_rdata=0x80FF_0000 -> mem_addr=0x8000_0000, wdata=0xFFFF_FF80; repeat as LBU -> 0x0000_0080.
REQ-028 LH with addr offset 2 and mem_rdata=0x8001_7FFF -> wdata=0xFFFF_8001; LHU -> 0x0000_8001; rd=0 -> wb_done=1, reg_wen=0.
REQ-029 mem_req_ready held low for 3 cycles -> mem_req_valid held 3 cycles with a stable mem_addr; a stray mem_resp_valid in IDLE -> no write.
REQ-030 rst asserted in WAIT, then response arrives -> no reg_wen; with the macro and TIMEOUT_CYCLES=4 and no response -> err=1 after 4 WAIT cycles, return to IDLE, no write.
